sd_acq_window_ctrl: RTL
=======================

# sd_acq_window_ctrl

Consumer-side controller for the DDS-clocked acquisition timer. It raises the timer enable `s_acq` on a start request and reads the timer's 22-bit `count` back. It skips a programmed dead time, then emits decimated ADC sample strobes with a running sample index, and closes the window when `count` reaches the programmed acquisition length. It sits between the pulse-sequence state machine (start/abort, config) and the ADC capture/FIFO path (strobes, index, done).

## Interface
Parameters:
- `CNT_W`, 22, width of timer count and length/skip registers
- `DIV_W`, 8, width of sample divider
- `IDX_W`, 12, width of sample index

Ports:
- `dds`  in  1  DDS clock, sole clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  one-cycle request to open a window; honoured only in IDLE
- `abort`  in  1  force return to IDLE; overrides all other inputs except `rst`
- `acq_len`  in  CNT_W  window length in counts; sampled on accepted `start`
- `skip_len`  in  CNT_W  dead time in counts before the first strobe; sampled on `start`
- `samp_div`  in  DIV_W  strobe every `samp_div+1` counts; sampled on `start`
- `count`  in  CNT_W  timer count fed back from the acquisition timer
- `s_acq`  out  1  timer enable / window-open flag
- `samp_strobe`  out  1  one-cycle ADC sample request
- `samp_idx`  out  IDX_W  index of the current strobe, starting at 0
- `busy`  out  1  high in any state other than IDLE
- `acq_done`  out  1  one-cycle pulse when the window closes normally
- `idx_ovf`  out  1  sticky; set when the window is cut short by index saturation
- `cnt_err`  out  1  sticky; set when `count` fails to advance by exactly +1 while open

## Operation
- States: IDLE, DEAD, SAMP, DONE.
- Reset: all outputs 0, state IDLE, config registers 0.
- IDLE -> DEAD on `start`. Latch config. Clear `samp_idx`, `idx_ovf`, `cnt_err`.
- DEAD: `s_acq`=1.
  - If `count >= acq_len`, go to DONE.
  - Else if `count >= skip_len`, go to SAMP and preload the divider to 0.
- SAMP: `s_acq`=1. Divider runs 0..`samp_div`, then wraps.
  - `samp_strobe`=1 in each cycle where the divider is 0.
  - `samp_idx` increments after each strobe.
- SAMP -> DONE when `count >= acq_len`. The end condition has priority; no strobe in that cycle.
- SAMP -> DONE when a strobe is issued at `samp_idx` = 2^IDX_W−1. Set `idx_ovf`.
- DONE: `s_acq`=0, `acq_done`=1 for exactly one cycle, then IDLE. `acq_done` is also asserted on index-saturation exits.
- `abort` in any state: next state IDLE, `s_acq`=0. No `acq_done`. Sticky flags are kept.
- `start` is ignored while `busy`=1.
- `start` and `abort` in the same cycle: `abort` wins.
- Count monitor, from the second open cycle onward: if `count != prev_count+1`, set `cnt_err`. The window keeps running.
- All comparisons are unsigned, CNT_W bits. No wrap: `acq_len` ≤ 2^CNT_W−1 guarantees termination before the count rolls over.

## Timing
- `start` at edge T -> DEAD and `s_acq`=1 from T+1.
- Timer `count` reads 0 at T+1, 1 at T+2, and so on.
- DEAD->SAMP decision is registered: first strobe one cycle after `count` first equals `skip_len`.
- `acq_len`=0: DONE at T+2. `s_acq` is high for one cycle, zero strobes.
- `skip_len ≥ acq_len`: zero strobes; DONE when `count` = `acq_len`.
- `samp_div`=0: one strobe per cycle.
- `acq_done` is asserted in the cycle `s_acq` drops.
- Strobe outputs are registered, with no combinational path from `count`.
- `rst` mid-window: IDLE on the next edge, `s_acq` low. The timer clears itself on `s_acq` low.

## Structure
- Package `sd_acq_pkg`: state enum (IDLE/DEAD/SAMP/DONE) and the CNT_W, DIV_W, IDX_W defaults.
- Sub-module `sd_samp_div`: divider counter with load, enable, and a terminal-count output.
- The top level holds the FSM, config latches, index counter and count monitor.

## Test plan
- `skip_len`=10, `acq_len`=50, `samp_div`=3, ideal timer model -> strobes when `count` = 11, 15, …, 47 (10 strobes, idx 0..9); `acq_done` one cycle; `s_acq` low after.
- `acq_len`=0 -> `s_acq` high one cycle, no strobe, `acq_done` at T+2.
- `samp_div`=0, IDX_W=4, `acq_len`=100, `skip_len`=0 -> 16 strobes, then `idx_ovf`=1 and `acq_done`.
- `abort` at count 20 mid-SAMP -> IDLE next cycle, no `acq_done`. A fresh `start` runs a clean window and clears the flags.
- Timer model skips count 30->32 -> `cnt_err` sets and stays set, window completes normally.
- `start` during `busy`, and `start` with `abort` in the same cycle -> ignored, and IDLE respectively.

Source files
------------

// File: rtl/sd_acq_window_ctrl_pkg.sv
// sd_acq_pkg: state encoding and default widths shared by the acquisition window controller
package sd_acq_pkg;
   localparam int CNT_W_DEF = 22;
   localparam int DIV_W_DEF = 8;
   localparam int IDX_W_DEF = 12;
   typedef enum logic [1:0] {IDLE, DEAD, SAMP, DONE} acq_state_t;
endpackage

// File: rtl/sd_acq_window_ctrl_if.sv
// sd_acq_window_ctrl_if: sequencer/timer side to window controller signal bundle
interface sd_acq_window_ctrl_if
   import sd_acq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DIV_W = DIV_W_DEF,
   parameter int IDX_W = IDX_W_DEF
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] acq_len;
   logic [CNT_W-1:0] skip_len;
   logic [DIV_W-1:0] samp_div;
   logic [CNT_W-1:0] count;
   logic             s_acq;
   logic             samp_strobe;
   logic [IDX_W-1:0] samp_idx;
   logic             busy;
   logic             acq_done;
   logic             idx_ovf;
   logic             cnt_err;
   modport master (
      output start, abort, acq_len, skip_len, samp_div, count,
      input  s_acq, samp_strobe, samp_idx, busy, acq_done, idx_ovf, cnt_err
   );
   modport slave (
      input  start, abort, acq_len, skip_len, samp_div, count,
      output s_acq, samp_strobe, samp_idx, busy, acq_done, idx_ovf, cnt_err
   );
endinterface

// File: rtl/sd_acq_window_ctrl_samp_div.sv
// sd_samp_div: sample divider counting 0..div with load-to-zero and terminal-count flag
module sd_samp_div
   import sd_acq_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             dds,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tc
);
   logic [DIV_W-1:0] cnt;
   assign tc = cnt == div;
   // Modulo-(div+1) counter, held at zero while loading
   always_ff @(posedge dds) begin
      if (rst || load) cnt <= '0;
      else if (en) cnt <= tc ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/sd_acq_window_ctrl.sv
// sd_acq_window_ctrl: opens the acquisition window, issues decimated sample strobes, closes on length or index saturation
module sd_acq_window_ctrl
   import sd_acq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DIV_W = DIV_W_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input logic                dds,
   input logic                rst,
   sd_acq_window_ctrl_if.slave bus
);
   acq_state_t       state;
   logic [CNT_W-1:0] acq_len_q;
   logic [CNT_W-1:0] skip_len_q;
   logic [CNT_W-1:0] prev_count;
   logic [DIV_W-1:0] samp_div_q;
   logic             div_tc;
   logic             prev_vld;
   logic             accept;
   logic             at_len;
   assign accept = state == IDLE && bus.start && !bus.abort;
   assign at_len = bus.count >= acq_len_q;
   sd_samp_div #(.DIV_W(DIV_W)) u_div (
      .dds  (dds),
      .rst  (rst),
      .load (state == DEAD),
      .en   (state == SAMP),
      .div  (samp_div_q),
      .tc   (div_tc)
   );
   // Window sequencing; every output is registered from the next-state decision so nothing reaches a pin from count
   always_ff @(posedge dds) begin
      if (rst) begin
         state           <= IDLE;
         acq_len_q       <= '0;
         skip_len_q      <= '0;
         samp_div_q      <= '0;
         bus.s_acq       <= 1'b0;
         bus.samp_strobe <= 1'b0;
         bus.samp_idx    <= '0;
         bus.busy        <= 1'b0;
         bus.acq_done    <= 1'b0;
         bus.idx_ovf     <= 1'b0;
      end else begin
         bus.samp_strobe <= 1'b0;
         bus.acq_done    <= 1'b0;
         if (bus.abort) begin
            state     <= IDLE;
            bus.s_acq <= 1'b0;
            bus.busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (bus.start) begin
                  state        <= DEAD;
                  acq_len_q    <= bus.acq_len;
                  skip_len_q   <= bus.skip_len;
                  samp_div_q   <= bus.samp_div;
                  bus.s_acq    <= 1'b1;
                  bus.busy     <= 1'b1;
                  bus.samp_idx <= '0;
                  bus.idx_ovf  <= 1'b0;
               end
               DEAD: if (at_len) begin
                  state        <= DONE;
                  bus.s_acq    <= 1'b0;
                  bus.acq_done <= 1'b1;
               end else if (bus.count >= skip_len_q) begin
                  state           <= SAMP;
                  bus.samp_strobe <= 1'b1;
               end
               SAMP: begin
                  if (bus.samp_strobe && !(&bus.samp_idx)) bus.samp_idx <= bus.samp_idx + 1'b1;
                  if (at_len || (bus.samp_strobe && &bus.samp_idx)) begin
                     state        <= DONE;
                     bus.s_acq    <= 1'b0;
                     bus.acq_done <= 1'b1;
                     if (!at_len) bus.idx_ovf <= 1'b1;
                  end else begin
                     bus.samp_strobe <= div_tc;
                  end
               end
               default: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            endcase
         end
      end
   end
   // Count monitor: every open cycle after the first must see the timer advance by exactly one
   always_ff @(posedge dds) begin
      if (rst || accept) begin
         bus.cnt_err <= 1'b0;
         prev_vld    <= 1'b0;
         prev_count  <= '0;
      end else begin
         prev_vld   <= bus.s_acq;
         prev_count <= bus.count;
         if (bus.s_acq && prev_vld && bus.count != prev_count + 1'b1) bus.cnt_err <= 1'b1;
      end
   end
endmodule
